// File: rtl/dispatch.sv
// Dispatch stage: single-entry holding register between rename and the ROB/issue queues,
// plus the physical-register busy table used to tag source-operand readiness.

package dispatch_pkg;
    localparam int PREG_W = 7;

    typedef struct packed {
        logic [31:0]       pc;
        logic [15:0]       op;
        logic              fu_alu;
        logic              fu_br;
        logic              fu_mem;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd_new;
    } rename_data;
endpackage

module dispatch
    import dispatch_pkg::*;
#(
    parameter int NUM_PREGS = 128,
    parameter int PREG_W    = dispatch_pkg::PREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  rename_data        data_in,
    output logic              ready_in,
    input  logic              mispredict,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_preg,
    output logic              rob_valid,
    input  logic              rob_ready,
    output logic              alu_valid,
    output logic              br_valid,
    output logic              mem_valid,
    input  logic              alu_ready,
    input  logic              br_ready,
    input  logic              mem_ready,
    output rename_data        iq_data,
    output logic              iq_ps1_rdy,
    output logic              iq_ps2_rdy,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        TGT_ALU = 2'd0,
        TGT_BR  = 2'd1,
        TGT_MEM = 2'd2
    } target_e;

    logic                 held_r;
    rename_data           data_r;
    logic                 ps1_rdy_r;
    logic                 ps2_rdy_r;
    logic [31:0]          stall_cnt_r;
    logic [NUM_PREGS-1:0] busy_r;

    target_e              target_s;
    logic                 q_ready_s;
    logic                 fire_s;
    logic                 accept_s;
    logic                 new_ps1_rdy_s;
    logic                 new_ps2_rdy_s;
    logic                 hold_ps1_rdy_s;
    logic                 hold_ps2_rdy_s;
    logic [NUM_PREGS-1:0] busy_next_s;

    // A source is ready if it is p0, not busy, or being written back this very cycle.
    function automatic logic src_ready(
        input logic [PREG_W-1:0]    ps,
        input logic [NUM_PREGS-1:0] busy,
        input logic                 cv,
        input logic [PREG_W-1:0]    cp
    );
        return (ps == {PREG_W{1'b0}}) || !busy[ps] || (cv && (cp == ps));
    endfunction

    // Target queue selection, priority br > mem > alu, and the queue-ready mux.
    always_comb begin
        target_s  = TGT_ALU;
        q_ready_s = 1'b0;
        if (data_r.fu_br) begin
            target_s = TGT_BR;
        end else if (data_r.fu_mem) begin
            target_s = TGT_MEM;
        end else begin
            target_s = TGT_ALU;
        end
        case (target_s)
            TGT_ALU: q_ready_s = alu_ready;
            TGT_BR:  q_ready_s = br_ready;
            TGT_MEM: q_ready_s = mem_ready;
            default: q_ready_s = 1'b0;
        endcase
    end

    // Handshake: each side's strobe waits only on the other side's ready, so ROB and queue
    // write together or not at all.
    always_comb begin
        fire_s    = held_r && rob_ready && q_ready_s;
        ready_in  = !held_r || fire_s;
        accept_s  = valid_in && ready_in && !mispredict;
        rob_valid = held_r && q_ready_s;
        alu_valid = 1'b0;
        br_valid  = 1'b0;
        mem_valid = 1'b0;
        case (target_s)
            TGT_ALU: alu_valid = held_r && rob_ready;
            TGT_BR:  br_valid  = held_r && rob_ready;
            TGT_MEM: mem_valid = held_r && rob_ready;
            default: begin
                alu_valid = 1'b0;
                br_valid  = 1'b0;
                mem_valid = 1'b0;
            end
        endcase
    end

    // Readiness for a newly accepted entry (pre-update table) and for the held entry.
    always_comb begin
        new_ps1_rdy_s  = src_ready(data_in.ps1, busy_r, cdb_valid, cdb_preg);
        new_ps2_rdy_s  = src_ready(data_in.ps2, busy_r, cdb_valid, cdb_preg);
        hold_ps1_rdy_s = ps1_rdy_r || (cdb_valid && (cdb_preg == data_r.ps1));
        hold_ps2_rdy_s = ps2_rdy_r || (cdb_valid && (cdb_preg == data_r.ps2));
    end

    // Busy-table update: writeback clears, allocation sets, set wins on a collision.
    always_comb begin
        busy_next_s = busy_r;
        if (cdb_valid) begin
            busy_next_s[cdb_preg] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (accept_s && (data_in.pd_new != {PREG_W{1'b0}})) begin
            busy_next_s[data_in.pd_new] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Holding register; a flush drops it but a same-cycle fire has already been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_r    <= 1'b0;
            data_r    <= '0;
            ps1_rdy_r <= 1'b0;
            ps2_rdy_r <= 1'b0;
        end else if (mispredict) begin
            held_r <= 1'b0;
        end else if (accept_s) begin
            held_r    <= 1'b1;
            data_r    <= data_in;
            ps1_rdy_r <= new_ps1_rdy_s;
            ps2_rdy_r <= new_ps2_rdy_s;
        end else if (fire_s) begin
            held_r <= 1'b0;
        end else if (held_r) begin
            ps1_rdy_r <= hold_ps1_rdy_s;
            ps2_rdy_r <= hold_ps2_rdy_s;
        end
    end

    // Physical-register busy table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NUM_PREGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Saturating count of cycles an entry sat without dispatching.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (held_r && !fire_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign iq_data    = data_r;
    assign iq_ps1_rdy = ps1_rdy_r;
    assign iq_ps2_rdy = ps2_rdy_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_dispatch.sv
// Directed table-driven bench for dispatch plus hand-written reset sequences.

module tb_dispatch;
    import dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    rename_data  data_in;
    logic        ready_in;
    logic        mispredict;
    logic        cdb_valid;
    logic [6:0]  cdb_preg;
    logic        rob_valid;
    logic        rob_ready;
    logic        alu_valid, br_valid, mem_valid;
    logic        alu_ready, br_ready, mem_ready;
    rename_data  iq_data;
    logic        iq_ps1_rdy, iq_ps2_rdy;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    dispatch dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .mispredict(mispredict), .cdb_valid(cdb_valid),
        .cdb_preg(cdb_preg), .rob_valid(rob_valid), .rob_ready(rob_ready),
        .alu_valid(alu_valid), .br_valid(br_valid), .mem_valid(mem_valid),
        .alu_ready(alu_ready), .br_ready(br_ready), .mem_ready(mem_ready),
        .iq_data(iq_data), .iq_ps1_rdy(iq_ps1_rdy), .iq_ps2_rdy(iq_ps2_rdy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vin;
        rename_data d;
        logic       misp;
        logic       cdbv;
        int         cdbp;
        logic       robr, alur, brr, memr;
        logic       e_rin, e_rob, e_alu, e_br, e_mem, e_p1, e_p2;
        int         e_stall;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fu = {br, mem, alu}
    function automatic rename_data mk(input logic [2:0] fu, input int p1, input int p2,
                                      input int pd, input int tag);
        rename_data r;
        r.pc     = 32'h0000_1000 + 32'(tag * 4);
        r.op     = 16'hA500 + 16'(tag);
        r.fu_br  = fu[2];
        r.fu_mem = fu[1];
        r.fu_alu = fu[0];
        r.ps1    = 7'(p1);
        r.ps2    = 7'(p2);
        r.pd_new = 7'(pd);
        return r;
    endfunction

    task automatic add(input logic vin, input rename_data d, input logic misp, input logic cdbv,
                       input int cdbp, input logic robr, input logic alur, input logic brr,
                       input logic memr, input logic rin, input logic rob, input logic alu,
                       input logic br, input logic mem, input logic p1, input logic p2,
                       input int st);
        vecs[nv] = '{vin, d, misp, cdbv, cdbp, robr, alur, brr, memr,
                     rin, rob, alu, br, mem, p1, p2, st};
        nv++;
    endtask

    rename_data z, i1, i2, i3, i4, i5, i6, i7, i8, i9, i10, ia, ib, exp_data;

    initial begin
        z   = '0;
        i1  = mk(3'b001, 5, 0, 40, 1);
        i2  = mk(3'b001, 40, 0, 41, 2);
        i3  = mk(3'b001, 41, 40, 42, 3);
        i4  = mk(3'b100, 42, 0, 43, 4);
        i5  = mk(3'b010, 43, 41, 44, 5);
        i6  = mk(3'b010, 44, 0, 45, 6);
        i7  = mk(3'b001, 45, 0, 46, 7);
        i8  = mk(3'b001, 46, 45, 0, 8);
        i9  = mk(3'b001, 0, 44, 40, 9);
        i10 = mk(3'b001, 40, 0, 0, 10);
        ia  = mk(3'b000, 44, 0, 47, 11);
        ib  = mk(3'b001, 44, 42, 48, 12);

        //  vin d    mp cv cp  rr ar br mr   rin rob alu br mem p1 p2 stall
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 0, 0);
        add(1, i1,  0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 0, 0);
        add(1, i2,  0, 1, 40, 1, 1, 1, 1,   1,  1,  1,  0, 0,  1, 1, 0);
        add(1, i3,  0, 0, 0,  1, 1, 1, 1,   1,  1,  1,  0, 0,  1, 1, 0);
        add(0, z,   0, 0, 0,  1, 0, 1, 1,   0,  0,  1,  0, 0,  0, 1, 0);
        add(0, z,   0, 1, 41, 1, 0, 1, 1,   0,  0,  1,  0, 0,  0, 1, 1);
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  1,  1,  0, 0,  1, 1, 2);
        add(1, i4,  0, 0, 0,  1, 1, 0, 1,   1,  0,  0,  0, 0,  1, 1, 2);
        add(1, i5,  0, 0, 0,  1, 1, 0, 1,   0,  0,  0,  1, 0,  0, 1, 2);
        add(1, i5,  0, 0, 0,  1, 1, 0, 1,   0,  0,  0,  1, 0,  0, 1, 3);
        add(1, i5,  0, 0, 0,  1, 1, 0, 1,   0,  0,  0,  1, 0,  0, 1, 4);
        add(1, i5,  0, 0, 0,  1, 1, 1, 1,   1,  1,  0,  1, 0,  0, 1, 5);
        add(0, z,   0, 0, 0,  0, 1, 1, 1,   0,  1,  0,  0, 0,  0, 1, 5);
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  1,  0,  0, 1,  0, 1, 6);
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 1, 6);
        add(1, i6,  0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 1, 6);
        add(1, i7,  1, 0, 0,  1, 1, 1, 0,   0,  0,  0,  0, 1,  0, 1, 6);
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 1, 7);
        add(1, i8,  0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 1, 7);
        add(1, i9,  0, 1, 40, 1, 1, 1, 1,   1,  1,  1,  0, 0,  1, 0, 7);
        add(1, i10, 0, 0, 0,  1, 1, 1, 1,   1,  1,  1,  0, 0,  1, 0, 7);
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  1,  1,  0, 0,  0, 1, 7);
        add(0, z,   0, 0, 0,  1, 1, 1, 1,   1,  0,  0,  0, 0,  0, 1, 7);

        reset = 1'b1; valid_in = 1'b0; data_in = '0; mispredict = 1'b0;
        cdb_valid = 1'b0; cdb_preg = 7'd0; rob_ready = 1'b1;
        alu_ready = 1'b1; br_ready = 1'b1; mem_ready = 1'b1;

        #2;
        chk("rst_ready_in", 72'(ready_in), 72'd1);
        chk("rst_valids", 72'({rob_valid, alu_valid, br_valid, mem_valid}), 72'd0);
        chk("rst_iq_data", 72'(iq_data), 72'd0);
        chk("rst_ps_rdy", 72'({iq_ps1_rdy, iq_ps2_rdy}), 72'd0);
        chk("rst_stall", 72'(stall_cnt), 72'd0);

        @(negedge clk);
        reset = 1'b0;
        exp_data = '0;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            valid_in   = vecs[i].vin;
            data_in    = vecs[i].d;
            mispredict = vecs[i].misp;
            cdb_valid  = vecs[i].cdbv;
            cdb_preg   = 7'(vecs[i].cdbp);
            rob_ready  = vecs[i].robr;
            alu_ready  = vecs[i].alur;
            br_ready   = vecs[i].brr;
            mem_ready  = vecs[i].memr;
            #2;
            chk($sformatf("v%0d_ready_in", i), 72'(ready_in), 72'(vecs[i].e_rin));
            chk($sformatf("v%0d_rob_valid", i), 72'(rob_valid), 72'(vecs[i].e_rob));
            chk($sformatf("v%0d_alu_valid", i), 72'(alu_valid), 72'(vecs[i].e_alu));
            chk($sformatf("v%0d_br_valid", i), 72'(br_valid), 72'(vecs[i].e_br));
            chk($sformatf("v%0d_mem_valid", i), 72'(mem_valid), 72'(vecs[i].e_mem));
            chk($sformatf("v%0d_ps1_rdy", i), 72'(iq_ps1_rdy), 72'(vecs[i].e_p1));
            chk($sformatf("v%0d_ps2_rdy", i), 72'(iq_ps2_rdy), 72'(vecs[i].e_p2));
            chk($sformatf("v%0d_stall", i), 72'(stall_cnt), 72'(vecs[i].e_stall));
            chk($sformatf("v%0d_iq_data", i), 72'(iq_data), 72'(exp_data));
            if (vecs[i].vin && vecs[i].e_rin && !vecs[i].misp) exp_data = vecs[i].d;
        end

        // Reset mid-operation: held entry dropped at once, busy table cleared.
        @(negedge clk);
        valid_in = 1'b1; data_in = ia; mispredict = 1'b0; cdb_valid = 1'b0;
        rob_ready = 1'b1; alu_ready = 1'b1; br_ready = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; alu_ready = 1'b0;
        #2;
        chk("mid_held_alu_valid", 72'(alu_valid), 72'd1);
        chk("mid_held_ready_in", 72'(ready_in), 72'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valids", 72'({rob_valid, alu_valid, br_valid, mem_valid}), 72'd0);
        chk("mid_rst_ready_in", 72'(ready_in), 72'd1);
        chk("mid_rst_iq_data", 72'(iq_data), 72'd0);
        chk("mid_rst_stall", 72'(stall_cnt), 72'd0);
        @(negedge clk);
        reset = 1'b0; alu_ready = 1'b1; valid_in = 1'b1; data_in = ib;
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        chk("post_rst_ps1_rdy", 72'(iq_ps1_rdy), 72'd1);
        chk("post_rst_ps2_rdy", 72'(iq_ps2_rdy), 72'd1);
        chk("post_rst_alu_valid", 72'(alu_valid), 72'd1);
        chk("post_rst_iq_data", 72'(iq_data), 72'(ib));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispatch.md
Name: dispatch

Overview:
- Stage directly downstream of rename. Accepts one renamed instruction per cycle (rename_data) and holds it in a single-entry dispatch register.
- Allocates it into the ROB and routes it to exactly one issue queue: ALU, branch or memory.
- Owns the physical-register busy table. Tags each dispatched instruction with ps1/ps2 readiness, tracked against CDB writeback broadcasts.

Parameters:
- NUM_PREGS, 128, number of physical registers; busy-table depth.
- PREG_W, 7, physical register index width; must equal $clog2(NUM_PREGS).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  rename output valid
- data_in  in  rename_data  renamed instruction
- ready_in  out  1  dispatch can accept data_in this cycle
- mispredict  in  1  flush from ROB
- cdb_valid  in  1  writeback broadcast valid
- cdb_preg  in  PREG_W  physical register written back
- rob_valid  out  1  ROB allocation request
- rob_ready  in  1  ROB has a free entry
- alu_valid / br_valid / mem_valid  out  1 each  issue-queue write strobe
- alu_ready / br_ready / mem_ready  in  1 each  issue queue not full
- iq_data  out  rename_data  held instruction; shared by ROB and all queues
- iq_ps1_rdy, iq_ps2_rdy  out  1 each  source operand already available
- stall_cnt  out  32  cycles with held entry not dispatched

Behaviour:
- Reset: asynchronous, active-high; resets the design on assertion regardless of clk.
  - Values on reset: held=0; iq_data=0; iq_ps1_rdy=iq_ps2_rdy=0; stall_cnt=0; busy table all 0 (all ready).
  - All valids deassert immediately (they are combinational from held).
- Target select, from the held fu bits, priority br > mem > alu.
  - fu_br → br; else fu_mem → mem; else alu. All-zero fu bits route to alu.
- Signals:
  - q_ready = ready of the target queue.
  - fire = held && rob_ready && q_ready.
  - rob_valid = held && q_ready.
  - Target *_valid = held && rob_ready; non-target valids = 0.
  - ROB and the queue therefore write in the same cycle or neither does. Valids never depend on the valid they produce.
- ready_in = !held || fire.
- Accept = valid_in && ready_in && !mispredict. On accept, the dispatch register loads data_in and held=1.
  - iq_ps1_rdy = (ps1==0) || !busy[ps1] || (cdb_valid && cdb_preg==ps1). iq_ps2_rdy is computed the same way.
- fire without accept → held=0 next cycle. fire with accept → back-to-back; held stays 1 with the new data. Latency is 1 cycle from accept to earliest dispatch.
- While held: a cdb broadcast matching the held ps1/ps2 sets iq_ps1_rdy/iq_ps2_rdy next cycle. Ready bits never clear while held.
- Busy table (NUM_PREGS bits, bit 0 hardwired 0):
  - cdb_valid clears busy[cdb_preg].
  - Accept with pd_new≠0 sets busy[pd_new].
  - Same index set and cleared in the same cycle → set wins.
  - Accepting an instruction whose ps equals the pd_new being set this cycle uses the pre-update value plus the cdb bypass.
- mispredict (1 cycle): held←0 and no accept that cycle. fire is still honoured if it is true that cycle (the older instruction already committed to ROB/IQ).
  - The busy table is not rolled back. Squashed pd_new bits stay set until reallocation and writeback. This is harmless because no surviving instruction names them.
- stall_cnt: +1 each cycle held && !fire. Saturates at 32'hFFFF_FFFF. Never cleared except by reset.
- Reset mid-operation: the held instruction is dropped, no partial ROB/IQ write, busy table cleared.

Test Plan:
- Reset, then ALU instr (fu_alu=1, ps1=5, ps2=0, pd_new=40), all readies=1 → alu_valid and rob_valid high cycle after accept; iq_ps1_rdy=1, iq_ps2_rdy=1; busy[40]=1.
- Next instr reads ps1=40; cdb_valid=1, cdb_preg=40 in its accept cycle → iq_ps1_rdy=1 (bypass); without cdb → 0; then cdb in a later cycle → 1 the following cycle.
- Branch held with br_ready=0 for 3 cycles → br_valid=1, rob_valid=0, ready_in=0, stall_cnt=3; br_ready=1 → fire; a new accept occurs in the same cycle.
- rob_ready=0 with mem instr (fu_mem=1) → mem_valid=0, rob_valid=1, no dispatch; rob_ready=1 → both strobes high in one cycle, exactly one write.
- mispredict while held and mem_ready=0, valid_in=1 → held=0 next cycle, no valids; data_in not accepted that cycle; busy bits unchanged.
- cdb_preg=40 clear and accept pd_new=40 in the same cycle → busy[40]=1; pd_new=0 accept → busy[0] remains 0.
